ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch.sv | 109 ++++++++++
 tb/tb_ifu_prefetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: fetch pointer, internal instruction memory
// and a small circular queue of {pc, inst} with redirect handling.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h3000,
    parameter int          DEPTH    = 4,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redir_valid,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] redir_pc,
    input  logic [25:0] imm26,
    input  logic [31:0] register,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        redir_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(IM_WORDS);

    localparam logic [1:0] SEL_NORM = 2'd0;
    localparam logic [1:0] SEL_REL  = 2'd1;
    localparam logic [1:0] SEL_IRR  = 2'd2;
    localparam logic [1:0] SEL_REG  = 2'd3;

    logic [31:0]   im [0:IM_WORDS-1];

    logic [31:0]   fpc;
    logic [31:0]   target;
    logic [31:0]   fetch_inst;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          misalign_nxt;

    assign fetch_inst = im[fpc[AW+1:2]];
    assign out_valid  = (count != '0);
    assign out_pc     = q_pc[rd_ptr];
    assign out_inst   = q_inst[rd_ptr];

    // A full queue may still fetch when the head leaves on the same edge.
    assign pop  = out_valid && out_ready;
    assign push = !redir_valid && ((count != CW'(DEPTH)) || pop);

    assign misalign_nxt = redir_valid && (npc_sel == SEL_REG)
                          && (register[1:0] != 2'b00);

    // Redirect target selection.
    always_comb begin
        target = redir_pc + 32'd4;
        unique case (npc_sel)
            SEL_NORM: target = redir_pc + 32'd4;
            SEL_REL:  target = redir_pc + 32'd4
                             + {{14{imm26[15]}}, imm26[15:0], 2'b00};
            SEL_IRR:  target = {redir_pc[31:28], imm26, 2'b00};
            SEL_REG:  target = {register[31:2], 2'b00};
        endcase
    end

    // Queue storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= fpc;
            q_inst[wr_ptr] <= fetch_inst;
        end
    end

    // Fetch pointer, queue pointers, occupancy and misalign pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc            <= RESET_PC;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            redir_misalign <= 1'b0;
        end else begin
            redir_misalign <= misalign_nxt;
            if (redir_valid) begin
                fpc    <= target;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    fpc    <= fpc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a queue-level model predicts the
// delivered stream, a negedge monitor pops and compares.
module tb_ifu_prefetch;

    localparam logic [31:0] RPC   = 32'h3000;
    localparam int          DEPTH = 4;
    localparam int          IMW   = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  npc_sel = 2'd0;
    logic [31:0] redir_pc = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] register = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redir_misalign;

    ifu_prefetch #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH),
        .IM_WORDS (IMW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redir_valid    (redir_valid),
        .npc_sel        (npc_sel),
        .redir_pc       (redir_pc),
        .imm26          (imm26),
        .register       (register),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redir_misalign (redir_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic [31:0] mem [IMW];
    ent_t        exp_q [$];
    logic [31:0] m_fpc = RPC;
    logic        m_mis = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Redirect target from the mode rules, as plain arithmetic.
    function automatic logic [31:0] tgt(input logic [1:0] sel,
                                        input logic [31:0] pc,
                                        input logic [25:0] imm,
                                        input logic [31:0] rg);
        int off;
        off = int'($signed(imm[15:0])) * 4;
        case (sel)
            2'd0:    return pc + 32'd4;
            2'd1:    return pc + 32'd4 + 32'(off);
            2'd2:    return (pc & 32'hf000_0000) | (32'(imm) * 4);
            default: return rg & ~32'd3;
        endcase
    endfunction

    // Model: at each active edge either flush to the new target or fetch.
    always @(posedge clk) begin
        if (reset) begin
            if (redir_valid) begin
                exp_q.delete();
                m_fpc = tgt(npc_sel, redir_pc, imm26, register);
                m_mis = (npc_sel == 2'd3) && (register % 4 != 0);
            end else begin
                m_mis = 1'b0;
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back('{m_fpc, mem[(m_fpc / 4) % IMW]});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // Reset discards everything the model holds.
    always @(negedge reset) begin
        exp_q.delete();
        m_fpc = RPC;
        m_mis = 1'b0;
    end

    // Monitor: compare the presented head; pop when it will be taken.
    always @(negedge clk) begin
        ent_t e;
        if (reset) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("redir_misalign", 32'(redir_misalign), 32'(m_mis));
            if (exp_q.size() != 0) begin
                if (out_ready) begin
                    e = exp_q.pop_front();
                end else begin
                    e = exp_q[0];
                end
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        redir_valid = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    // Wait for the head to become valid; checks value and latency.
    task automatic wait_head(input string name, input logic [31:0] exp,
                             input int lat);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check({name, "_pc"}, out_pc, exp);
        if (lat > 0) check({name, "_lat"}, 32'(n), 32'(lat));
        #1;
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] pc,
                            input logic [25:0] imm, input logic [31:0] rg);
        @(posedge clk);
        #1;
        redir_valid = 1'b1;
        npc_sel     = sel;
        redir_pc    = pc;
        imm26       = imm;
        register    = rg;
        tick(1);
        redir_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < IMW; i++) begin
            mem[i]    = $urandom;
            dut.im[i] = mem[i];
        end
        reset = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_misalign", 32'(redir_misalign), 32'd0);

        // Boot stream with the consumer always ready.
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        wait_head("boot", 32'h3000, 2);
        tick(6);

        // Back-pressure then drain.
        do_reset();
        out_ready = 1'b0;
        tick(10);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head", out_pc, 32'h3000);
        out_ready = 1'b1;
        tick(12);

        // Relative redirects: zero offset, then -1 word.
        redirect(2'd1, 32'h3004, 26'h0000, '0);
        wait_head("rel0", 32'h3008, 2);
        tick(3);
        redirect(2'd1, 32'h3008, 26'h0ffff, '0);
        wait_head("relm1", 32'h3008, 2);
        tick(3);

        // Absolute jump.
        redirect(2'd2, 32'h3010, 26'h1234, '0);
        wait_head("irr", 32'h48d0, 2);
        tick(3);

        // Register target with misaligned low bits.
        redirect(2'd3, '0, '0, 32'h300a);
        check("mis_pulse", 32'(redir_misalign), 32'd1);
        wait_head("reg", 32'h3008, 2);
        tick(3);

        // Asynchronous reset with a full queue.
        out_ready = 1'b0;
        tick(8);
        #3 reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        #3 reset = 1'b1;
        out_ready = 1'b1;
        wait_head("after_rst", 32'h3000, 0);

        // Randomised traffic, including back-to-back redirects.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                redir_valid = 1'b0;
                tick(1);
                reset = 1'b1;
            end
            out_ready   = ($urandom_range(0, 9) < 7);
            redir_valid = ($urandom_range(0, 9) == 0);
            npc_sel     = 2'($urandom_range(0, 3));
            redir_pc    = $urandom;
            imm26       = 26'($urandom);
            register    = $urandom;
        end
        @(posedge clk);
        #1 redir_valid = 1'b0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
